// File: rtl/pipelined_decode_stage.sv
// Registered, handshaked instruction decode stage: one output register plus one skid entry,
// with issue held off while a multi-cycle divide/sqrt occupies the datapath.
module pipelined_decode_stage #(
  parameter int NUM_FALU = 4,
  parameter int IMM_W    = 2,
  parameter int DIV_LAT  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [5:0]            in_opcode,
  input  logic [IMM_W-1:0]      in_imm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [5:0]            out_opcode,
  output logic [IMM_W-1:0]      out_imm,
  output logic                  out_int_alu_en,
  output logic                  out_int_op2_sel,
  output logic [NUM_FALU-1:0]   out_falu_en,
  output logic [NUM_FALU-1:0]   out_falu_op1_sel,
  output logic [2*NUM_FALU-1:0] out_falu_op2_sel,
  output logic                  out_vreduce_en,
  output logic [2:0]            out_scalar_out_sel,
  output logic [2:0]            out_memory_op,
  output logic                  out_illegal,
  output logic                  err_illegal,
  output logic                  busy
);

  localparam int CNT_W = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DIV_LAT - 1);

  typedef struct packed {
    logic [5:0]            opcode;
    logic [IMM_W-1:0]      imm;
    logic                  int_alu_en;
    logic                  int_op2_sel;
    logic [NUM_FALU-1:0]   falu_en;
    logic [NUM_FALU-1:0]   falu_op1_sel;
    logic [2*NUM_FALU-1:0] falu_op2_sel;
    logic                  vreduce_en;
    logic [2:0]            scalar_out_sel;
    logic [2:0]            memory_op;
    logic                  illegal;
    logic                  long_op;
  } bundle_t;

  bundle_t              dec;
  bundle_t              out_q, out_d;
  bundle_t              skid_q, skid_d;
  logic                 out_full_q, out_full_d;
  logic                 skid_full_q, skid_full_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic [NUM_FALU-1:0]  lane_hit;
  logic [2*NUM_FALU-1:0] lane_put_sel;
  logic                 imm_in_range;
  logic                 issue;
  logic                 accept;
  logic                 out_load;

  // Lane addressed by the immediate for the scalar<->lane transfer ops.
  for (genvar gi = 0; gi < NUM_FALU; gi++) begin : g_lane
    assign lane_hit[gi]             = (32'(in_imm) == gi);
    assign lane_put_sel[2*gi +: 2]  = lane_hit[gi] ? 2'b11 : 2'b00;
  end

  assign imm_in_range = (32'(in_imm) < NUM_FALU);

  always_comb begin
    dec        = '0;
    dec.opcode = in_opcode;
    dec.imm    = in_imm;
    case (in_opcode) inside
      6'b0000??, 6'b000101: begin
        dec.falu_en = '1;
      end
      6'b0010??: begin
        dec.falu_en      = '1;
        dec.falu_op2_sel = {NUM_FALU{2'b01}};
      end
      6'b0011??, 6'b0110??: begin
        dec.int_alu_en     = 1'b1;
        dec.scalar_out_sel = 3'b001;
      end
      6'b1010??: begin
        dec.int_alu_en     = 1'b1;
        dec.int_op2_sel    = 1'b1;
        dec.scalar_out_sel = 3'b001;
      end
      6'b0100??, 6'b010101: begin
        dec.falu_en[0]         = 1'b1;
        dec.falu_op1_sel[0]    = 1'b1;
        dec.falu_op2_sel[1:0]  = 2'b01;
        dec.scalar_out_sel     = 3'b010;
      end
      6'b100110: begin
        dec.falu_en[0]         = 1'b1;
        dec.falu_op1_sel[0]    = 1'b1;
        dec.falu_op2_sel[1:0]  = 2'b10;
        dec.scalar_out_sel     = 3'b010;
      end
      6'b100111: begin
        if (imm_in_range) begin
          dec.falu_en      = lane_hit;
          dec.falu_op2_sel = lane_put_sel;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      6'b100101: begin
        if (imm_in_range) dec.scalar_out_sel = 3'b100;
        else              dec.illegal        = 1'b1;
      end
      6'b100100: begin
        dec.vreduce_en     = 1'b1;
        dec.scalar_out_sel = 3'b101;
      end
      6'b10001?: begin
        dec.int_alu_en     = 1'b1;
        dec.scalar_out_sel = 3'b110;
      end
      6'b101100: begin
        dec.memory_op      = 3'b001;
        dec.scalar_out_sel = 3'b011;
      end
      6'b111100: dec.memory_op = 3'b010;
      6'b101111: dec.memory_op = 3'b011;
      6'b111111: dec.memory_op = 3'b100;
      6'b1100??, 6'b110100, 6'b110110, 6'b110111, 6'b111000, 6'b111011: begin
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.long_op = (in_opcode inside {6'b000011, 6'b001011, 6'b010011,
                                     6'b011011, 6'b101011, 6'b100110});
  end

  assign out_valid = out_full_q && (cnt_q == '0);
  assign issue     = out_valid && out_ready;
  assign in_ready  = !skid_full_q;
  assign accept    = in_valid && !skid_full_q;
  assign out_load  = !out_full_q || issue;

  always_comb begin
    out_d       = out_q;
    out_full_d  = out_full_q;
    skid_d      = skid_q;
    skid_full_d = skid_full_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    // Skid entry has priority into the output register to keep program order.
    if (out_load) begin
      if (skid_full_q) begin
        out_d       = skid_q;
        out_full_d  = 1'b1;
        skid_full_d = 1'b0;
      end else if (accept) begin
        out_d      = dec;
        out_full_d = 1'b1;
      end else begin
        out_full_d = 1'b0;
      end
    end else if (accept) begin
      skid_d      = dec;
      skid_full_d = 1'b1;
    end
    if (issue && out_q.long_op) begin
      cnt_d = CNT_RELOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
    if (issue && out_q.illegal) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= '0;
      out_full_q  <= 1'b0;
      skid_q      <= '0;
      skid_full_q <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_full_q  <= out_full_d;
      skid_q      <= skid_d;
      skid_full_q <= skid_full_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  assign out_opcode         = out_q.opcode;
  assign out_imm            = out_q.imm;
  assign out_int_alu_en     = out_q.int_alu_en;
  assign out_int_op2_sel    = out_q.int_op2_sel;
  assign out_falu_en        = out_q.falu_en;
  assign out_falu_op1_sel   = out_q.falu_op1_sel;
  assign out_falu_op2_sel   = out_q.falu_op2_sel;
  assign out_vreduce_en     = out_q.vreduce_en;
  assign out_scalar_out_sel = out_q.scalar_out_sel;
  assign out_memory_op      = out_q.memory_op;
  assign out_illegal        = out_q.illegal;
  assign err_illegal        = err_q;
  assign busy               = (cnt_q != '0);

endmodule

// File: tb/tb_pipelined_decode_stage.sv
// Directed bench: decode table, streaming, long-op stall, skid backpressure,
// lane-range checks on a 3-lane instance, and reset during a stall.
module tb_pipelined_decode_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 4-lane instance
  logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [5:0] in_opcode = '0, out_opcode;
  logic [1:0] in_imm = '0, out_imm;
  logic       int_alu_en, int_op2_sel, vreduce_en, illegal, err, busy;
  logic [3:0] falu_en, falu_op1;
  logic [7:0] falu_op2;
  logic [2:0] sso, mem_op;

  pipelined_decode_stage #(.NUM_FALU(4), .IMM_W(2), .DIV_LAT(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_imm(out_imm), .out_int_alu_en(int_alu_en),
    .out_int_op2_sel(int_op2_sel), .out_falu_en(falu_en), .out_falu_op1_sel(falu_op1),
    .out_falu_op2_sel(falu_op2), .out_vreduce_en(vreduce_en), .out_scalar_out_sel(sso),
    .out_memory_op(mem_op), .out_illegal(illegal), .err_illegal(err), .busy(busy)
  );

  // 3-lane instance, single-cycle long ops
  logic       b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1;
  logic [5:0] b_in_opcode = '0, b_out_opcode;
  logic [1:0] b_in_imm = '0, b_out_imm;
  logic       b_int_alu_en, b_int_op2_sel, b_vreduce_en, b_illegal, b_err, b_busy;
  logic [2:0] b_falu_en, b_falu_op1;
  logic [5:0] b_falu_op2;
  logic [2:0] b_sso, b_mem_op;

  pipelined_decode_stage #(.NUM_FALU(3), .IMM_W(2), .DIV_LAT(1)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_opcode(b_in_opcode), .in_imm(b_in_imm), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_opcode(b_out_opcode), .out_imm(b_out_imm), .out_int_alu_en(b_int_alu_en),
    .out_int_op2_sel(b_int_op2_sel), .out_falu_en(b_falu_en), .out_falu_op1_sel(b_falu_op1),
    .out_falu_op2_sel(b_falu_op2), .out_vreduce_en(b_vreduce_en), .out_scalar_out_sel(b_sso),
    .out_memory_op(b_mem_op), .out_illegal(b_illegal), .err_illegal(b_err), .busy(b_busy)
  );

  int checks = 0;
  int errors = 0;

  logic [25:0] act_bundle;
  assign act_bundle = {illegal, int_alu_en, int_op2_sel, falu_en, falu_op1, falu_op2,
                       vreduce_en, sso, mem_op};

  typedef struct {
    logic [5:0]  op;
    logic [1:0]  imm;
    logic [25:0] exp;
  } vec_t;

  function automatic logic [25:0] ex(input logic ill, input logic ia, input logic isel,
                                     input logic [3:0] fen, input logic [3:0] op1,
                                     input logic [7:0] op2, input logic vr,
                                     input logic [2:0] s, input logic [2:0] m);
    return {ill, ia, isel, fen, op1, op2, vr, s, m};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    chk("idle_timeout", 64'(busy), 64'(0));
  endtask

  vec_t tbl[21];
  logic [5:0] order_q[$];
  int busy_cnt;

  initial begin
    tbl[0]  = '{6'b000001, 2'd0, ex(0,0,0,4'hF,4'h0,8'h00,0,3'd0,3'd0)};
    tbl[1]  = '{6'b000101, 2'd0, ex(0,0,0,4'hF,4'h0,8'h00,0,3'd0,3'd0)};
    tbl[2]  = '{6'b001001, 2'd0, ex(0,0,0,4'hF,4'h0,8'h55,0,3'd0,3'd0)};
    tbl[3]  = '{6'b001110, 2'd0, ex(0,1,0,4'h0,4'h0,8'h00,0,3'd1,3'd0)};
    tbl[4]  = '{6'b101010, 2'd1, ex(0,1,1,4'h0,4'h0,8'h00,0,3'd1,3'd0)};
    tbl[5]  = '{6'b010101, 2'd0, ex(0,0,0,4'h1,4'h1,8'h01,0,3'd2,3'd0)};
    tbl[6]  = '{6'b100110, 2'd0, ex(0,0,0,4'h1,4'h1,8'h02,0,3'd2,3'd0)};
    tbl[7]  = '{6'b100111, 2'd2, ex(0,0,0,4'h4,4'h0,8'h30,0,3'd0,3'd0)};
    tbl[8]  = '{6'b100111, 2'd3, ex(0,0,0,4'h8,4'h0,8'hC0,0,3'd0,3'd0)};
    tbl[9]  = '{6'b100101, 2'd1, ex(0,0,0,4'h0,4'h0,8'h00,0,3'd4,3'd0)};
    tbl[10] = '{6'b100100, 2'd0, ex(0,0,0,4'h0,4'h0,8'h00,1,3'd5,3'd0)};
    tbl[11] = '{6'b100010, 2'd0, ex(0,1,0,4'h0,4'h0,8'h00,0,3'd6,3'd0)};
    tbl[12] = '{6'b101100, 2'd0, ex(0,0,0,4'h0,4'h0,8'h00,0,3'd3,3'd1)};
    tbl[13] = '{6'b111100, 2'd0, ex(0,0,0,4'h0,4'h0,8'h00,0,3'd0,3'd2)};
    tbl[14] = '{6'b101111, 2'd0, ex(0,0,0,4'h0,4'h0,8'h00,0,3'd0,3'd3)};
    tbl[15] = '{6'b111111, 2'd0, ex(0,0,0,4'h0,4'h0,8'h00,0,3'd0,3'd4)};
    tbl[16] = '{6'b110110, 2'd0, ex(0,0,0,4'h0,4'h0,8'h00,0,3'd0,3'd0)};
    tbl[17] = '{6'b000100, 2'd0, ex(1,0,0,4'h0,4'h0,8'h00,0,3'd0,3'd0)};
    tbl[18] = '{6'b000000, 2'd0, ex(0,0,0,4'hF,4'h0,8'h00,0,3'd0,3'd0)};
    tbl[19] = '{6'b111001, 2'd0, ex(1,0,0,4'h0,4'h0,8'h00,0,3'd0,3'd0)};
    tbl[20] = '{6'b110101, 2'd0, ex(1,0,0,4'h0,4'h0,8'h00,0,3'd0,3'd0)};

    // Reset state
    repeat (3) tick();
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_bundle", 64'(act_bundle), 64'(0));
    rst = 1'b0;
    tick();

    // Decode table, one instruction at a time
    out_ready = 1'b1;
    for (int i = 0; i < 21; i++) begin
      in_valid = 1'b1; in_opcode = tbl[i].op; in_imm = tbl[i].imm;
      tick();
      in_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(1));
      chk($sformatf("vec%0d_bundle", i), 64'(act_bundle), 64'(tbl[i].exp));
      $display("vec %0d op=%b imm=%0d bundle=%h", i, tbl[i].op, tbl[i].imm, act_bundle);
      tick();
      wait_idle();
    end
    chk("err_after_illegal", 64'(err), 64'(1));

    // Back-to-back stream
    in_valid = 1'b1; in_opcode = 6'b011000; in_imm = 2'd0;
    tick();
    chk("s1_valid", 64'(out_valid), 64'(1));
    chk("s1_int", 64'({out_opcode, int_alu_en, int_op2_sel}), 64'({6'b011000, 1'b1, 1'b0}));
    $display("stream op=%b int=%b sel=%b", out_opcode, int_alu_en, int_op2_sel);
    in_opcode = 6'b101001; in_imm = 2'd2;
    tick();
    chk("s2_valid", 64'(out_valid), 64'(1));
    chk("s2_int", 64'({out_opcode, out_imm, int_alu_en, int_op2_sel}),
        64'({6'b101001, 2'd2, 1'b1, 1'b1}));
    $display("stream op=%b int=%b sel=%b", out_opcode, int_alu_en, int_op2_sel);
    in_opcode = 6'b010010; in_imm = 2'd0;
    tick();
    chk("s3_valid", 64'(out_valid), 64'(1));
    chk("s3_ff", 64'({out_opcode, falu_en, sso}), 64'({6'b010010, 4'b0001, 3'b010}));
    $display("stream op=%b falu_en=%b sso=%b", out_opcode, falu_en, sso);
    in_valid = 1'b0;
    tick();
    chk("s_drained", 64'(out_valid), 64'(0));

    // Long op stall: vv_div then vv_add
    in_valid = 1'b1; in_opcode = 6'b000011;
    tick();
    chk("div_valid", 64'({out_valid, out_opcode}), 64'({1'b1, 6'b000011}));
    in_opcode = 6'b000000;
    tick();
    in_valid = 1'b0;
    busy_cnt = 0;
    for (int n = 0; n < 20 && !out_valid; n++) begin
      if (busy) busy_cnt++;
      tick();
    end
    chk("div_busy_cycles", 64'(busy_cnt), 64'(7));
    chk("add_after_div", 64'({out_valid, out_opcode, falu_en, falu_op2}),
        64'({1'b1, 6'b000000, 4'hF, 8'h00}));
    $display("long op: busy cycles=%0d next op=%b", busy_cnt, out_opcode);
    tick();

    // Backpressure fills output and skid; release preserves order
    out_ready = 1'b0;
    in_valid = 1'b1; in_opcode = 6'b011001;
    tick();
    chk("bp_ready_after_1", 64'(in_ready), 64'(1));
    in_opcode = 6'b001000;
    tick();
    chk("bp_ready_after_2", 64'(in_ready), 64'(0));
    in_opcode = 6'b100100;
    tick();
    chk("bp_hold", 64'({out_valid, out_opcode, in_ready}), 64'({1'b1, 6'b011001, 1'b0}));
    out_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      logic acc;
      acc = in_valid && in_ready;
      if (out_valid) order_q.push_back(out_opcode);
      tick();
      if (acc) in_valid = 1'b0;
    end
    chk("bp_count", 64'(order_q.size()), 64'(3));
    if (order_q.size() == 3) begin
      chk("bp_order", 64'({order_q[0], order_q[1], order_q[2]}),
          64'({6'b011001, 6'b001000, 6'b100100}));
      $display("backpressure order %b %b %b", order_q[0], order_q[1], order_q[2]);
    end

    // 3-lane instance: lane select range and sticky error, no stall with DIV_LAT=1
    b_in_valid = 1'b1; b_in_opcode = 6'b100111; b_in_imm = 2'd2;
    tick();
    chk("b_lane2", 64'({b_out_valid, b_illegal, b_falu_en, b_falu_op2}),
        64'({1'b1, 1'b0, 3'b100, 6'b110000}));
    $display("3-lane put imm=2 falu_en=%b op2=%b", b_falu_en, b_falu_op2);
    b_in_imm = 2'd3;
    tick();
    chk("b_lane3_illegal", 64'({b_out_valid, b_illegal, b_falu_en, b_falu_op2}),
        64'({1'b1, 1'b1, 3'b000, 6'b000000}));
    chk("b_err_before", 64'(b_err), 64'(0));
    b_in_opcode = 6'b000011; b_in_imm = 2'd0;
    tick();
    chk("b_err_set", 64'(b_err), 64'(1));
    chk("b_long", 64'({b_out_valid, b_out_opcode}), 64'({1'b1, 6'b000011}));
    b_in_opcode = 6'b000000;
    tick();
    chk("b_no_stall", 64'({b_out_valid, b_out_opcode, b_busy, b_falu_en}),
        64'({1'b1, 6'b000000, 1'b0, 3'b111}));
    b_in_valid = 1'b0;
    tick();
    chk("b_err_sticky", 64'(b_err), 64'(1));
    $display("3-lane err_illegal=%b busy=%b", b_err, b_busy);

    // Reset during a stall with the skid full
    in_valid = 1'b1; in_opcode = 6'b000011;
    tick();
    in_opcode = 6'b000001;
    tick();
    in_opcode = 6'b001000;
    tick();
    chk("pre_rst_state", 64'({in_ready, busy, out_valid}), 64'({1'b0, 1'b1, 1'b0}));
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_state", 64'({in_ready, busy, out_valid, err}), 64'({1'b1, 1'b0, 1'b0, 1'b0}));
    chk("mid_rst_bundle", 64'({out_opcode, act_bundle}), 64'(0));
    $display("reset mid-stall in_ready=%b busy=%b out_valid=%b", in_ready, busy, out_valid);
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_idle", 64'({out_valid, busy, in_ready}), 64'({1'b0, 1'b0, 1'b1}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
